msi_cache_dm: RTL and testbench

Parametrised direct-mapped, write-back, MSI-coherent private cache sitting between one core and the shared snoop bus and main memory. It generalises the fixed 32-line, 9-bit-address, single-cycle cache in three ways: configurable geometry, a handshaked miss and write-back sequencer, and explicit bus arbitration. It also adds an asynchronous reset. Snooping runs concurrently with the core-side FSM every cycle.

---
 rtl/msi_pkg.sv | 33 +++
 rtl/msi_snoop_ctrl.sv | 56 +++++
 rtl/msi_cache_dm.sv | 231 +++++++++++++++++++++++
 tb/tb_msi_cache_dm.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msi_pkg.sv
// Shared types for the direct-mapped MSI cache: line states,
// bus opcodes, core FSM states and small encoding helpers.
package msi_pkg;

  typedef enum logic [1:0] {
    ST_I = 2'b00,
    ST_M = 2'b01,
    ST_S = 2'b10
  } line_st_e;

  typedef enum logic [1:0] {
    OP_INV = 2'b00,
    OP_WM  = 2'b01,
    OP_RM  = 2'b10
  } bus_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WB   = 3'd1,
    S_BUS  = 3'd2,
    S_FILL = 3'd3,
    S_RESP = 3'd4
  } fsm_e;

  function automatic bus_op_e miss_op(input logic wr);
    return wr ? OP_WM : OP_RM;
  endfunction

  function automatic line_st_e fill_st(input logic wr);
    return wr ? ST_M : ST_S;
  endfunction

endpackage

// File: rtl/msi_snoop_ctrl.sv
// Snoop match and MSI downgrade logic for one cache line,
// purely combinational; the owner applies the returned update.
module msi_snoop_ctrl
  import msi_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 5,
  localparam int TAG_W  = ADDR_W - INDEX_W
) (
  input  logic               i_snoop_valid,
  input  logic [1:0]         i_snoop_op,
  input  logic [ADDR_W-1:0]  i_snoop_addr,
  input  line_st_e           i_line_st,
  input  logic [TAG_W-1:0]   i_line_tag,
  input  logic [DATA_W-1:0]  i_line_data,
  output logic [INDEX_W-1:0] o_snp_idx,
  output logic               o_snp_upd,
  output line_st_e           o_snp_st,
  output logic               o_snoop_hit,
  output logic [DATA_W-1:0]  o_snoop_data
);

  logic w_match;
  logic w_mod;

  assign o_snp_idx = i_snoop_addr[INDEX_W-1:0];
  assign w_mod     = (i_line_st == ST_M);
  assign w_match   = i_snoop_valid
                  && (i_line_st != ST_I)
                  && (i_line_tag == i_snoop_addr[ADDR_W-1:INDEX_W]);

  assign o_snoop_data = w_match ? i_line_data : '0;

  always_comb begin
    o_snp_upd   = 1'b0;
    o_snp_st    = ST_I;
    o_snoop_hit = 1'b0;
    unique case (1'b1)
      w_match && (i_snoop_op == OP_RM): begin
        o_snp_upd   = w_mod;
        o_snp_st    = ST_S;
        o_snoop_hit = w_mod;
      end
      w_match && (i_snoop_op == OP_WM): begin
        o_snp_upd   = 1'b1;
        o_snoop_hit = w_mod;
      end
      w_match && (i_snoop_op == OP_INV): begin
        o_snp_upd = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/msi_cache_dm.sv
// Direct-mapped write-back MSI private cache with a handshaked
// miss/write-back sequencer; snooping runs alongside every cycle.
module msi_cache_dm
  import msi_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              bus_req_valid,
  output logic [1:0]        bus_req_op,
  output logic [ADDR_W-1:0] bus_req_addr,
  input  logic              bus_grant,
  input  logic              peer_data_valid,
  input  logic [DATA_W-1:0] peer_data,
  input  logic              snoop_valid,
  input  logic [1:0]        snoop_op,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_hit,
  output logic [DATA_W-1:0] snoop_data,
  output logic              mem_req_valid,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef struct packed {
    fsm_e              fsm;
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    bus_op_e           op;
    logic [DATA_W-1:0] rdata;
    logic              bus_v;
    logic              mem_v;
    logic              mem_w;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
  } ctx_t;

  logic [LINES-1:0][1:0] r_st;
  logic [TAG_W-1:0]      r_tag  [LINES];
  logic [DATA_W-1:0]     r_data [LINES];
  ctx_t                  r_q;
  ctx_t                  w_d;

  logic               w_idle;
  logic [ADDR_W-1:0]  w_addr;
  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  line_st_e           w_ln_st;
  logic [TAG_W-1:0]   w_ln_tag;
  logic [DATA_W-1:0]  w_ln_data;
  logic               w_hit;
  logic               w_st_we;
  logic               w_tag_we;
  logic               w_dat_we;
  logic               w_fill;
  line_st_e           w_st_nxt;
  logic [DATA_W-1:0]  w_dat_nxt;
  logic [DATA_W-1:0]  w_fdata;
  logic [INDEX_W-1:0] w_snp_idx;
  logic               w_snp_upd;
  line_st_e           w_snp_st;

  // IDLE looks up the incoming request, later states the latched one
  assign w_idle    = (r_q.fsm == S_IDLE);
  assign w_addr    = w_idle ? cpu_addr : r_q.addr;
  assign w_idx     = w_addr[INDEX_W-1:0];
  assign w_tag     = w_addr[ADDR_W-1:INDEX_W];
  assign w_ln_st   = line_st_e'(r_st[w_idx]);
  assign w_ln_tag  = r_tag[w_idx];
  assign w_ln_data = r_data[w_idx];
  assign w_hit     = (w_ln_st != ST_I) && (w_ln_tag == w_tag);
  assign w_fdata   = peer_data_valid ? peer_data : mem_rdata;

  assign cpu_ready      = w_idle;
  assign cpu_resp_valid = (r_q.fsm == S_RESP);
  assign cpu_rdata      = r_q.rdata;
  assign bus_req_valid  = r_q.bus_v;
  assign bus_req_op     = r_q.op;
  assign bus_req_addr   = r_q.addr;
  assign mem_req_valid  = r_q.mem_v;
  assign mem_req_write  = r_q.mem_w;
  assign mem_addr       = r_q.mem_addr;
  assign mem_wdata      = r_q.mem_wdata;

  msi_snoop_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .INDEX_W (INDEX_W)
  ) u_snoop (
    .i_snoop_valid (snoop_valid),
    .i_snoop_op    (snoop_op),
    .i_snoop_addr  (snoop_addr),
    .i_line_st     (line_st_e'(r_st[w_snp_idx])),
    .i_line_tag    (r_tag[w_snp_idx]),
    .i_line_data   (r_data[w_snp_idx]),
    .o_snp_idx     (w_snp_idx),
    .o_snp_upd     (w_snp_upd),
    .o_snp_st      (w_snp_st),
    .o_snoop_hit   (snoop_hit),
    .o_snoop_data  (snoop_data)
  );

  always_comb begin
    w_d       = r_q;
    w_st_we   = 1'b0;
    w_st_nxt  = ST_I;
    w_tag_we  = 1'b0;
    w_dat_we  = 1'b0;
    w_dat_nxt = r_q.wdata;
    w_fill    = 1'b0;
    unique case (r_q.fsm)
      S_IDLE: begin
        if (cpu_req_valid) begin
          w_d.addr  = cpu_addr;
          w_d.wr    = cpu_req_write;
          w_d.wdata = cpu_wdata;
          unique case (1'b1)
            w_hit && !cpu_req_write: begin
              w_d.rdata = w_ln_data;
              w_d.fsm   = S_RESP;
            end
            w_hit && cpu_req_write && (w_ln_st == ST_M): begin
              w_dat_we  = 1'b1;
              w_dat_nxt = cpu_wdata;
              w_d.fsm   = S_RESP;
            end
            w_hit && cpu_req_write && (w_ln_st == ST_S): begin
              w_d.bus_v = 1'b1;
              w_d.op    = OP_INV;
              w_d.fsm   = S_BUS;
            end
            !w_hit && (w_ln_st == ST_M): begin
              w_d.mem_v     = 1'b1;
              w_d.mem_w     = 1'b1;
              w_d.mem_addr  = {w_ln_tag, w_idx};
              w_d.mem_wdata = w_ln_data;
              w_d.fsm       = S_WB;
            end
            default: begin
              w_d.bus_v = 1'b1;
              w_d.op    = miss_op(cpu_req_write);
              w_d.fsm   = S_BUS;
            end
          endcase
        end
      end
      S_WB: begin
        if (mem_ack) begin
          w_st_we   = 1'b1;
          w_st_nxt  = ST_I;
          w_d.mem_v = 1'b0;
          w_d.mem_w = 1'b0;
          w_d.bus_v = 1'b1;
          w_d.op    = miss_op(r_q.wr);
          w_d.fsm   = S_BUS;
        end
      end
      S_BUS: begin
        if (bus_grant) begin
          w_d.bus_v = 1'b0;
          if (r_q.op == OP_INV && w_hit && w_ln_st == ST_S) begin
            w_st_we  = 1'b1;
            w_st_nxt = ST_M;
            w_dat_we = 1'b1;
            w_d.fsm  = S_RESP;
          end else begin
            // a lost upgrade is refetched as an ordinary write miss
            if (r_q.op == OP_INV) w_d.op = OP_WM;
            w_d.mem_v    = 1'b1;
            w_d.mem_w    = 1'b0;
            w_d.mem_addr = r_q.addr;
            w_d.fsm      = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (peer_data_valid || mem_ack) begin
          w_fill    = 1'b1;
          w_st_we   = 1'b1;
          w_st_nxt  = fill_st(r_q.wr);
          w_tag_we  = 1'b1;
          w_dat_we  = 1'b1;
          w_dat_nxt = r_q.wr ? r_q.wdata : w_fdata;
          if (!r_q.wr) w_d.rdata = w_fdata;
          w_d.mem_v = 1'b0;
          w_d.fsm   = S_RESP;
        end
      end
      S_RESP:  w_d.fsm = S_IDLE;
      default: w_d.fsm = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= '0;
    else     r_q <= w_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st <= '0;
    end else begin
      if (w_st_we) r_st[w_idx] <= w_st_nxt;
      if (w_snp_upd && !(w_fill && (w_snp_idx == w_idx)))
        r_st[w_snp_idx] <= w_snp_st;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tag_we) r_tag[w_idx]  <= w_tag;
    if (w_dat_we) r_data[w_idx] <= w_dat_nxt;
  end

endmodule

// File: tb/tb_msi_cache_dm.sv
// Randomised bench for msi_cache_dm: acts as memory, arbiter and
// peer, and predicts every transaction from an MSI line model.
module tb_msi_cache_dm;

  localparam logic [1:0] INV = 2'b00;
  localparam logic [1:0] WM  = 2'b01;
  localparam logic [1:0] RM  = 2'b10;

  typedef enum int {LI, LS, LM} mst_e;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid, cpu_req_write;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready, cpu_resp_valid;
  logic [31:0] cpu_rdata;
  logic        bus_req_valid;
  logic [1:0]  bus_req_op;
  logic [8:0]  bus_req_addr;
  logic        bus_grant, peer_data_valid;
  logic [31:0] peer_data;
  logic        snoop_valid;
  logic [1:0]  snoop_op;
  logic [8:0]  snoop_addr;
  logic        snoop_hit;
  logic [31:0] snoop_data;
  logic        mem_req_valid, mem_req_write;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  msi_cache_dm dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid),
    .cpu_rdata(cpu_rdata),
    .bus_req_valid(bus_req_valid), .bus_req_op(bus_req_op),
    .bus_req_addr(bus_req_addr), .bus_grant(bus_grant),
    .peer_data_valid(peer_data_valid), .peer_data(peer_data),
    .snoop_valid(snoop_valid), .snoop_op(snoop_op),
    .snoop_addr(snoop_addr), .snoop_hit(snoop_hit),
    .snoop_data(snoop_data),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  mst_e        ms [32];
  logic [3:0]  mt [32];
  logic [31:0] md [32];
  logic [31:0] mem [512];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic snoop_chk(input logic [1:0] op, input logic [8:0] a);
    int idx;
    bit match, exp_hit;
    idx = int'(a[4:0]);
    match = (ms[idx] != LI) && (mt[idx] == a[8:5]);
    exp_hit = match && (ms[idx] == LM) && (op != INV);
    @(negedge clk);
    snoop_valid = 1'b1;
    snoop_op = op;
    snoop_addr = a;
    #1;
    chk("snp_hit", snoop_hit, exp_hit);
    if (exp_hit) chk("snp_data", snoop_data, md[idx]);
    if (match) begin
      if (op == RM) begin
        if (ms[idx] == LM) ms[idx] = LS;
      end else begin
        ms[idx] = LI;
      end
    end
    @(negedge clk);
    snoop_valid = 1'b0;
  endtask

  task automatic do_req(input bit wr, input logic [8:0] a,
                        input logic [31:0] wd, input bit peer,
                        input logic [31:0] pv, input bit race,
                        input bit abort);
    int idx, cyc, dly;
    logic [3:0] tg;
    bit hit, exp_wb, exp_busq, exp_fill;
    bit done, wb_seen, bus_seen, fill_seen, raced;
    logic [1:0] exp_op;
    logic [8:0] wb_a;
    logic [31:0] wb_d, exp_rd;
    idx = int'(a[4:0]);
    tg = a[8:5];
    hit = (ms[idx] != LI) && (mt[idx] == tg);
    exp_wb = !hit && (ms[idx] == LM);
    wb_a = {mt[idx], a[4:0]};
    wb_d = md[idx];
    exp_busq = !(hit && (!wr || ms[idx] == LM));
    exp_op = hit ? INV : (wr ? WM : RM);
    exp_fill = !hit || race;
    exp_rd = md[idx];
    @(negedge clk);
    chk("ready", cpu_ready, 1'b1);
    cpu_req_valid = 1'b1;
    cpu_req_write = wr;
    cpu_addr = a;
    cpu_wdata = wd;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cyc = 1;
    done = 0;
    wb_seen = 0;
    bus_seen = 0;
    fill_seen = 0;
    raced = 0;
    dly = $urandom_range(0, 3);
    while (!done && cyc <= 60) begin
      if (cpu_resp_valid) begin
        done = 1;
        if (!exp_busq) chk("hit_lat", cyc, 1);
        chk("wb_seen", wb_seen, exp_wb);
        chk("bus_seen", bus_seen, exp_busq);
        chk("fill_seen", fill_seen, exp_fill);
        chk("mem_idle", mem_req_valid, 1'b0);
        if (!wr) chk("rdata", cpu_rdata, exp_rd);
      end else if (mem_req_valid && mem_req_write) begin
        if (dly == 0) begin
          chk("wb_addr", mem_addr, wb_a);
          chk("wb_data", mem_wdata, wb_d);
          mem[wb_a] = wb_d;
          mem_ack = 1'b1;
          wb_seen = 1;
          dly = $urandom_range(0, 3);
        end else dly--;
      end else if (bus_req_valid) begin
        if (race && !raced) begin
          snoop_valid = 1'b1;
          snoop_op = WM;
          snoop_addr = a;
          ms[idx] = LI;
          raced = 1;
        end else if (dly == 0) begin
          chk("bus_op", bus_req_op, exp_op);
          chk("bus_addr", bus_req_addr, a);
          chk("wb_first", wb_seen, exp_wb);
          bus_grant = 1'b1;
          bus_seen = 1;
          dly = $urandom_range(0, 3);
        end else dly--;
      end else if (mem_req_valid) begin
        if (abort) begin
          rst = 1'b1;
          #1;
          chk("rst_ready", cpu_ready, 1'b1);
          chk("rst_mem", mem_req_valid, 1'b0);
          chk("rst_bus", bus_req_valid, 1'b0);
          chk("rst_resp", cpu_resp_valid, 1'b0);
          chk("rst_rdata", cpu_rdata, 32'h0);
          @(negedge clk);
          rst = 1'b0;
          for (int i = 0; i < 32; i++) ms[i] = LI;
          done = 1;
        end else if (dly == 0) begin
          chk("fill_addr", mem_addr, a);
          fill_seen = 1;
          if (peer) begin
            peer_data_valid = 1'b1;
            peer_data = pv;
            exp_rd = pv;
          end else begin
            mem_ack = 1'b1;
            mem_rdata = mem[a];
            exp_rd = mem[a];
          end
        end else dly--;
      end
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
      bus_grant = 1'b0;
      peer_data_valid = 1'b0;
      snoop_valid = 1'b0;
    end
    if (!done) chk("timeout", 1'b0, 1'b1);
    if (done && !abort) begin
      if (hit && !race) begin
        if (wr) begin
          ms[idx] = LM;
          md[idx] = wd;
        end
      end else begin
        ms[idx] = wr ? LM : LS;
        mt[idx] = tg;
        md[idx] = wr ? wd : exp_rd;
      end
    end
  endtask

  initial begin
    logic [8:0] a;
    logic [1:0] op;
    rst = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_write = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    bus_grant = 1'b0;
    peer_data_valid = 1'b0;
    peer_data = '0;
    snoop_valid = 1'b0;
    snoop_op = '0;
    snoop_addr = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    for (int i = 0; i < 32; i++) begin
      ms[i] = LI;
      mt[i] = '0;
      md[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready0", cpu_ready, 1'b1);
    chk("rst_resp0", cpu_resp_valid, 1'b0);
    chk("rst_bus0", bus_req_valid, 1'b0);
    chk("rst_mem0", mem_req_valid, 1'b0);
    chk("rst_memw0", mem_req_write, 1'b0);
    chk("rst_snp0", snoop_hit, 1'b0);
    chk("rst_rdata0", cpu_rdata, 32'h0);
    rst = 1'b0;

    mem[9'h025] = 32'hDEADBEEF;
    do_req(0, 9'h025, 32'h0, 0, 32'h0, 0, 0);
    do_req(0, 9'h025, 32'h0, 0, 32'h0, 0, 0);
    do_req(1, 9'h025, 32'h11111111, 0, 32'h0, 0, 0);
    do_req(0, 9'h045, 32'h0, 0, 32'h0, 0, 0);
    do_req(1, 9'h025, 32'hCAFE0000, 0, 32'h0, 0, 0);
    snoop_chk(RM, 9'h025);
    do_req(1, 9'h025, 32'h22222222, 0, 32'h0, 0, 0);
    do_req(0, 9'h0A7, 32'h0, 1, 32'h12345678, 0, 0);
    do_req(1, 9'h0A7, 32'h33333333, 0, 32'h0, 1, 0);
    snoop_chk(WM, 9'h0A7);
    do_req(0, 9'h0C3, 32'h0, 0, 32'h0, 0, 1);
    snoop_chk(WM, 9'h025);
    do_req(0, 9'h025, 32'h0, 0, 32'h0, 0, 0);

    for (int k = 0; k < 250; k++) begin
      a[8:5] = 4'($urandom_range(0, 3));
      a[4:0] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        op = 2'($urandom_range(0, 2));
        snoop_chk(op, a);
      end else begin
        do_req(1'($urandom_range(0, 1)), a, $urandom,
               ($urandom_range(0, 3) == 0), $urandom, 0, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
